sample_sequencer: RTL and testbench
===================================

# sample_sequencer

Per-sample controller for the audio effects datapath. Generates the ADC conversion request every sample period and captures the returned sample. Drives the slot counter that steps the effects datapath through its read/accumulate slots, then strobes the RAM write and DAC load. After reset it first runs an offset calibration that averages the idle input to produce the DC offset the datapath subtracts.

## Interface
Parameters:
- FRAME_LEN, 1000: clock cycles per sample period; legal range 16..65535.
- CAL_LOG2, 4: log2 of the number of samples averaged during calibration; legal range 1..6.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- adc_start  out  1  one-cycle conversion request to the ADC interface
- adc_done  in  1  one-cycle pulse: adc_data valid this cycle
- adc_data  in  10  unsigned ADC result
- sample_voltage  out  10  last accepted sample, held between accepts
- offset  out  10  calibrated DC offset
- counter  out  10  slot index to the effects datapath
- ram_we  out  1  delay-RAM write enable
- send_load  out  1  DAC load strobe
- cal_done  out  1  calibration finished (level)
- overrun  out  1  sticky error flag

## Operation
- Frame timer: 16-bit count 0..FRAME_LEN-1, wraps to 0. frame_tick is asserted when the count is 0, starting from the first cycle after reset.
- FSM states and transitions:
  - CAL_WAIT: waits for a sample while calibrating.
  - CAL_IDLE: sample taken, waits for the next frame.
  - RUN_WAIT: waits for a sample in normal operation.
  - RUN_IDLE: sample taken, waits for the next frame.
  - Reset state is CAL_IDLE.
  - frame_tick in any state pulses adc_start, and the FSM enters the matching *_WAIT state.
- Accept: adc_done while in a *_WAIT state accepts adc_data, and the FSM moves to the matching *_IDLE state. adc_done in an *_IDLE state is ignored and has no side effects.
- Calibration: each accept adds adc_data to a (10+CAL_LOG2)-bit accumulator. After 2^CAL_LOG2 accepts:
  - offset is loaded with accumulator >> CAL_LOG2 (truncating).
  - cal_done is set and the FSM moves to RUN_IDLE.
  - During calibration, sample_voltage is not updated, counter stays 10'h3FF, and ram_we and send_load stay 0.
- Run accept:
  - sample_voltage is loaded with adc_data.
  - counter is set to 0 on the following edge, then increments every cycle, saturating at 10'h3FF.
  - ram_we is high when counter==5; send_load is high when counter==6.
- Overrun: overrun is set and stays set until reset when either:
  - frame_tick occurs while in a *_WAIT state (the conversion is reissued and waiting continues), or
  - a run accept occurs while counter<7. That sample is dropped: no counter restart and no sample_voltage update.
- A simultaneous frame_tick and adc_done in a *_WAIT state is treated as an accept followed by a new request:
  - the sample is accepted;
  - adc_start pulses;
  - the next state is *_WAIT;
  - overrun is not set.

## Timing
- Reset values: adc_start 0, sample_voltage 0, offset 0, counter 10'h3FF, ram_we 0, send_load 0, cal_done 0, overrun 0. The accumulator and frame count are 0.
- Reset asserted mid-frame or mid-calibration returns every register to its reset value immediately (asynchronous). Calibration restarts from scratch.
- adc_start is registered and is high in the cycle after the frame count equals 0.
- Accept in cycle N gives sample_voltage valid and counter=0 at edge N+1. ram_we is high in cycle N+6 and send_load in cycle N+7.
- ram_we and send_load are registered decodes of counter, each exactly one cycle wide.

## Structure
- Shared package seq_pkg holds:
  - the state enum {CAL_WAIT, CAL_IDLE, RUN_WAIT, RUN_IDLE};
  - the constants SLOT_WRITE=5, SLOT_SEND=6, SLOT_LAST=7 and COUNTER_IDLE=10'h3FF.
- One sub-module, frame_timer (parameter FRAME_LEN; output frame_tick), holds the free-running period counter.
- The FSM, calibration accumulator, slot counter and strobe decode stay in sample_sequencer.

## Test plan
Benches run with FRAME_LEN=16 and CAL_LOG2=2.
- Calibration: four frames, each returning adc_data=10'h200,10'h201,10'h202,10'h203 two cycles after adc_start -> offset=10'h201, cal_done set after the fourth accept, counter stays 10'h3FF throughout.
- Run frame: adc_data=10'h155 with adc_done 3 cycles after adc_start -> sample_voltage=10'h155, counter goes 0,1,2… from the next edge, ram_we only at counter 5, send_load only at counter 6, overrun stays 0.
- Missed conversion: no adc_done for a whole frame -> overrun=1, adc_start pulses again at the next frame; a later adc_done is accepted normally.
- Early duplicate: a second adc_done 3 cycles after an accept -> sample dropped, sample_voltage unchanged, counter unaffected, overrun=1.
- Simultaneous: adc_done in the same cycle as frame_tick while waiting -> sample accepted, adc_start pulses, overrun=0.
- Reset mid-calibration after 2 samples: all outputs return to their reset values asynchronously; 4 fresh samples are needed before cal_done.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and slot constants for the sample sequencer
package seq_pkg;
  typedef enum logic [1:0] {CAL_WAIT, CAL_IDLE, RUN_WAIT, RUN_IDLE} state_t;
  localparam logic [9:0] SLOT_WRITE = 10'd5;
  localparam logic [9:0] SLOT_SEND = 10'd6;
  localparam logic [9:0] SLOT_LAST = 10'd7;
  localparam logic [9:0] COUNTER_IDLE = 10'h3FF;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: free-running sample-period counter, ticks when the count is zero
module frame_timer #(
  parameter int FRAME_LEN = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);
  logic [15:0] count;
  // count 0..FRAME_LEN-1 and wrap
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= count == 16'(FRAME_LEN - 1) ? '0 : count + 16'd1;
  assign frame_tick = count == '0;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: per-sample ADC request, offset calibration and slot sequencing
module sample_sequencer import seq_pkg::*; #(
  parameter int FRAME_LEN = 1000,
  parameter int CAL_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [9:0] adc_data,
  output logic [9:0] sample_voltage,
  output logic [9:0] offset,
  output logic [9:0] counter,
  output logic       ram_we,
  output logic       send_load,
  output logic       cal_done,
  output logic       overrun
);
  state_t state;
  logic frame_tick;
  logic [CAL_LOG2-1:0] cal_cnt;
  logic [9+CAL_LOG2:0] acc;
  logic [9+CAL_LOG2:0] acc_sum;
  logic [9:0] counter_next;
  logic waiting, cal_mode, accept, cal_last, run_accept, run_ok;
  frame_timer #(.FRAME_LEN(FRAME_LEN)) u_frame_timer (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick)
  );
  assign waiting = state == CAL_WAIT || state == RUN_WAIT;
  assign cal_mode = state == CAL_WAIT || state == CAL_IDLE;
  assign accept = adc_done && waiting;
  assign cal_last = accept && cal_mode && &cal_cnt;
  assign run_accept = accept && !cal_mode;
  assign run_ok = run_accept && counter >= SLOT_LAST;
  assign acc_sum = acc + {{CAL_LOG2{1'b0}}, adc_data};
  assign counter_next = run_ok ? 10'd0 : counter == COUNTER_IDLE ? counter : counter + 10'd1;
  // sequencer FSM with calibration, slot counter and registered strobes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CAL_IDLE;
      adc_start <= 1'b0;
      sample_voltage <= '0;
      offset <= '0;
      counter <= COUNTER_IDLE;
      ram_we <= 1'b0;
      send_load <= 1'b0;
      cal_done <= 1'b0;
      overrun <= 1'b0;
      cal_cnt <= '0;
      acc <= '0;
    end else begin
      adc_start <= frame_tick;
      if (frame_tick) state <= cal_mode && !cal_last ? CAL_WAIT : RUN_WAIT;
      else if (accept) state <= cal_mode && !cal_last ? CAL_IDLE : RUN_IDLE;
      if (accept && cal_mode) begin
        acc <= acc_sum;
        cal_cnt <= cal_cnt + CAL_LOG2'(1);
      end
      if (cal_last) begin
        offset <= acc_sum[CAL_LOG2 +: 10];
        cal_done <= 1'b1;
      end
      if (run_ok) sample_voltage <= adc_data;
      counter <= counter_next;
      ram_we <= counter_next == SLOT_WRITE;
      send_load <= counter_next == SLOT_SEND;
      if ((frame_tick && waiting && !adc_done) || (run_accept && !run_ok)) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: table, directed and random checks against a timestamp-based model
module tb_sample_sequencer;
  localparam int FL = 16;
  localparam int NCAL = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic adc_done = 1'b0;
  logic [9:0] adc_data = '0;
  logic adc_start, ram_we, send_load, cal_done, overrun;
  logic [9:0] sample_voltage, offset, counter;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit waiting, calibrating, exp_cal_done, exp_overrun;
  int cal_sum, cal_n, acc_cyc;
  logic [9:0] exp_offset, exp_sv;
  typedef struct {
    int dly;
    logic [9:0] data;
    logic [9:0] sv;
    logic [9:0] off;
    bit cd;
    bit ov;
  } row_t;
  row_t rows[8];

  sample_sequencer #(.FRAME_LEN(FL), .CAL_LOG2(2)) dut (
    .clk(clk),
    .reset(reset),
    .adc_start(adc_start),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .sample_voltage(sample_voltage),
    .offset(offset),
    .counter(counter),
    .ram_we(ram_we),
    .send_load(send_load),
    .cal_done(cal_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [9:0] act, logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_clear();
    cyc = 0;
    waiting = 0;
    calibrating = 1;
    cal_sum = 0;
    cal_n = 0;
    acc_cyc = -1;
    exp_offset = '0;
    exp_sv = '0;
    exp_cal_done = 0;
    exp_overrun = 0;
  endfunction

  function automatic void model_edge(bit d, logic [9:0] data);
    bit tick = (cyc % FL) == 0;
    if (waiting && d) begin
      if (calibrating) begin
        cal_sum += int'(data);
        cal_n++;
        if (cal_n == NCAL) begin
          exp_offset = 10'(cal_sum / NCAL);
          exp_cal_done = 1;
          calibrating = 0;
        end
      end else if (acc_cyc < 0 || cyc - acc_cyc - 1 >= 7) begin
        exp_sv = data;
        acc_cyc = cyc;
      end else exp_overrun = 1;
      waiting = 0;
    end else if (waiting && tick) exp_overrun = 1;
    if (tick) waiting = 1;
    cyc++;
  endfunction

  function automatic void check_all();
    int k = cyc - acc_cyc - 1;
    chk("adc_start", 10'(adc_start), 10'(cyc >= 1 && (cyc - 1) % FL == 0));
    chk("counter", counter, acc_cyc < 0 || k > 1023 ? 10'h3FF : 10'(k));
    chk("ram_we", 10'(ram_we), 10'(acc_cyc >= 0 && k == 5));
    chk("send_load", 10'(send_load), 10'(acc_cyc >= 0 && k == 6));
    chk("sample_voltage", sample_voltage, exp_sv);
    chk("offset", offset, exp_offset);
    chk("cal_done", 10'(cal_done), 10'(exp_cal_done));
    chk("overrun", 10'(overrun), 10'(exp_overrun));
  endfunction

  task automatic step(input bit d, input logic [9:0] data);
    adc_done = d;
    adc_data = data;
    @(posedge clk);
    model_edge(d, data);
    #1;
    adc_done = 1'b0;
    check_all();
  endtask

  task automatic frame(input int dly, input logic [9:0] data);
    for (int i = 0; i < FL; i++) step(i == dly + 1, data);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_adc_start", 10'(adc_start), 10'h000);
    chk("rst_sample_voltage", sample_voltage, 10'h000);
    chk("rst_offset", offset, 10'h000);
    chk("rst_counter", counter, 10'h3FF);
    chk("rst_ram_we", 10'(ram_we), 10'h000);
    chk("rst_send_load", 10'(send_load), 10'h000);
    chk("rst_cal_done", 10'(cal_done), 10'h000);
    chk("rst_overrun", 10'(overrun), 10'h000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_all();
  endtask

  initial begin
    rows[0] = '{2, 10'h200, 10'h000, 10'h000, 1'b0, 1'b0};
    rows[1] = '{2, 10'h201, 10'h000, 10'h000, 1'b0, 1'b0};
    rows[2] = '{2, 10'h202, 10'h000, 10'h000, 1'b0, 1'b0};
    rows[3] = '{2, 10'h203, 10'h000, 10'h201, 1'b1, 1'b0};
    rows[4] = '{3, 10'h155, 10'h155, 10'h201, 1'b1, 1'b0};
    rows[5] = '{-2, 10'h000, 10'h155, 10'h201, 1'b1, 1'b0};
    rows[6] = '{5, 10'h0AA, 10'h0AA, 10'h201, 1'b1, 1'b1};
    rows[7] = '{-1, 10'h123, 10'h0AA, 10'h201, 1'b1, 1'b1};
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      frame(rows[r].dly, rows[r].data);
      chk("row_sample_voltage", sample_voltage, rows[r].sv);
      chk("row_offset", offset, rows[r].off);
      chk("row_cal_done", 10'(cal_done), 10'(rows[r].cd));
      chk("row_overrun", 10'(overrun), 10'(rows[r].ov));
    end
    do_reset();
    for (int i = 0; i < 4; i++) frame(2, 10'h100);
    frame(13, 10'h0F0);
    frame(0, 10'h333);
    chk("dup_sample_voltage", sample_voltage, 10'h0F0);
    chk("dup_overrun", 10'(overrun), 10'h001);
    chk("dup_counter", counter, 10'd17);
    do_reset();
    for (int i = 0; i < 4; i++) frame(2, 10'h100);
    frame(-2, 10'h000);
    frame(-1, 10'h2AA);
    chk("sim_sample_voltage", sample_voltage, 10'h2AA);
    chk("sim_overrun", 10'(overrun), 10'h000);
    do_reset();
    frame(2, 10'h3FF);
    frame(2, 10'h3FF);
    step(1'b0, 10'h000);
    do_reset();
    frame(2, 10'h010);
    frame(2, 10'h020);
    frame(2, 10'h030);
    chk("cal_restart_not_done", 10'(cal_done), 10'h000);
    frame(2, 10'h040);
    chk("cal_restart_done", 10'(cal_done), 10'h001);
    chk("cal_restart_offset", offset, 10'h028);
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int i = 0; i < 600; i++) step($urandom_range(0, 5) == 0, 10'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
